mvb_tx_scheduler: RTL and testbench

MVB_TX_SCHEDULER -- requirements
Module: mvb_tx_scheduler

---
 rtl/mvb_tx_scheduler.sv | 155 +++++++++++++++
 tb/tb_mvb_tx_scheduler.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mvb_tx_scheduler.sv
// MVB transmit scheduler: arbitrates master/slave frame requests, strobes the encoder,
// then waits for end-of-frame or a timeout before holding an inter-frame gap.
module mvb_tx_scheduler #(
  parameter int unsigned STROBE_CYC  = 16,
  parameter int unsigned GAP_CYC     = 48,
  parameter int unsigned TIMEOUT_CYC = 32767
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       m_req_i,
  input  logic [6:0] m_len_i,
  input  logic       s_req_i,
  input  logic [6:0] s_len_i,
  output logic       m_ack_o,
  output logic       s_ack_o,
  input  logic       frame_over_i,
  input  logic       decode_over_i,
  output logic       send_frame_o,
  output logic [6:0] data_length_o,
  output logic       master_frame_o,
  output logic       slave_frame_o,
  output logic       tx_busy_o,
  output logic       tx_done_o,
  output logic       tx_error_o
);

  localparam int unsigned MaxSg  = (STROBE_CYC > GAP_CYC) ? STROBE_CYC : GAP_CYC;
  localparam int unsigned CntMax = (TIMEOUT_CYC > MaxSg) ? TIMEOUT_CYC : MaxSg;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] StrobeLast  = CntW'(STROBE_CYC - 1);
  localparam logic [CntW-1:0] GapLast     = CntW'(GAP_CYC - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYC - 1);
  localparam logic [CntW-1:0] CntTop      = CntW'(CntMax);

  typedef enum logic [1:0] {StIdle, StStrobe, StWaitDone, StGap} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            fo_q;
  logic [6:0]      len_q, len_d;
  logic            master_q, master_d;
  logic            slave_q, slave_d;
  logic            m_ack_q, m_ack_d;
  logic            s_ack_q, s_ack_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic [6:0] grant_len;
  logic       len_bad;

  // Slave wins a simultaneous request; the master request is simply not taken.
  assign grant_len = s_req_i ? s_len_i : m_len_i;
  assign len_bad   = (grant_len == 7'd0) || (grant_len > 7'd64);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    master_d = master_q;
    slave_d  = slave_q;
    m_ack_d  = 1'b0;
    s_ack_d  = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!decode_over_i && (s_req_i || m_req_i)) begin
          len_d    = grant_len;
          slave_d  = s_req_i;
          master_d = ~s_req_i;
          s_ack_d  = s_req_i;
          m_ack_d  = ~s_req_i;
          cnt_d    = '0;
          if (len_bad) begin
            err_d   = 1'b1;
            state_d = StGap;
          end else begin
            state_d = StStrobe;
          end
        end
      end
      StStrobe: begin
        if (cnt_q == StrobeLast) begin
          cnt_d   = '0;
          state_d = StWaitDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitDone: begin
        if (frame_over_i && !fo_q) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = StGap;
        end else if (cnt_q == TimeoutLast) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = StGap;
        end else if (cnt_q != CntTop) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          cnt_d    = '0;
          master_d = 1'b0;
          slave_d  = 1'b0;
          state_d  = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      fo_q     <= 1'b0;
      len_q    <= '0;
      master_q <= 1'b0;
      slave_q  <= 1'b0;
      m_ack_q  <= 1'b0;
      s_ack_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fo_q     <= frame_over_i;
      len_q    <= len_d;
      master_q <= master_d;
      slave_q  <= slave_d;
      m_ack_q  <= m_ack_d;
      s_ack_q  <= s_ack_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Decoded straight from state so an asynchronous reset drops the strobe at once.
  assign send_frame_o   = (state_q == StStrobe);
  assign tx_busy_o      = (state_q != StIdle);
  assign data_length_o  = len_q;
  assign master_frame_o = master_q;
  assign slave_frame_o  = slave_q;
  assign m_ack_o        = m_ack_q;
  assign s_ack_o        = s_ack_q;
  assign tx_done_o      = done_q;
  assign tx_error_o     = err_q;

endmodule

// File: tb/tb_mvb_tx_scheduler.sv
// Directed bench for mvb_tx_scheduler with default parameters.
module tb_mvb_tx_scheduler;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       m_req_i, s_req_i;
  logic [6:0] m_len_i, s_len_i;
  logic       frame_over_i, decode_over_i;
  logic       m_ack_o, s_ack_o, send_frame_o, master_frame_o, slave_frame_o;
  logic [6:0] data_length_o;
  logic       tx_busy_o, tx_done_o, tx_error_o;

  int errors = 0;
  int checks = 0;

  mvb_tx_scheduler dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .m_req_i       (m_req_i),
    .m_len_i       (m_len_i),
    .s_req_i       (s_req_i),
    .s_len_i       (s_len_i),
    .m_ack_o       (m_ack_o),
    .s_ack_o       (s_ack_o),
    .frame_over_i  (frame_over_i),
    .decode_over_i (decode_over_i),
    .send_frame_o  (send_frame_o),
    .data_length_o (data_length_o),
    .master_frame_o(master_frame_o),
    .slave_frame_o (slave_frame_o),
    .tx_busy_o     (tx_busy_o),
    .tx_done_o     (tx_done_o),
    .tx_error_o    (tx_error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_strobe_end(output int n);
    n = 0;
    while (send_frame_o && n < 100) begin
      n++;
      step();
    end
  endtask

  task automatic wait_idle(output int n, output int sf, output int err, output int done,
                           output int ack);
    n = 0; sf = 0; err = 0; done = 0; ack = 0;
    while (tx_busy_o && n < 40000) begin
      n++;
      sf   += int'(send_frame_o);
      err  += int'(tx_error_o);
      done += int'(tx_done_o);
      ack  += int'(m_ack_o | s_ack_o);
      step();
    end
  endtask

  int n, sf, err, done, ack;

  initial begin
    rst_ni = 1'b0;
    m_req_i = 0; s_req_i = 0; m_len_i = 0; s_len_i = 0;
    frame_over_i = 0; decode_over_i = 0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i) rst_ni = 1'b1;
    step();
    check("rst_busy", tx_busy_o, 0);
    check("rst_send", send_frame_o, 0);
    check("rst_len", data_length_o, 0);
    check("rst_frames", {master_frame_o, slave_frame_o}, 0);
    check("rst_pulses", {m_ack_o, s_ack_o, tx_done_o, tx_error_o}, 0);

    // Master frame, length 1, frame_over 2000 cycles after strobe falls
    m_req_i = 1; m_len_i = 7'd1;
    step();
    check("m1_ack", m_ack_o, 1);
    check("m1_send", send_frame_o, 1);
    check("m1_master", master_frame_o, 1);
    check("m1_len", data_length_o, 1);
    check("m1_busy", tx_busy_o, 1);
    m_req_i = 0;
    wait_strobe_end(n);
    check("m1_strobe_len", n, 16);
    repeat (1999) step();
    check("m1_no_done_yet", tx_done_o, 0);
    frame_over_i = 1;
    step();
    check("m1_done", tx_done_o, 1);
    check("m1_master_held", master_frame_o, 1);
    check("m1_len_held", data_length_o, 1);
    frame_over_i = 0;
    wait_idle(n, sf, err, done, ack);
    check("m1_gap", n, 48);
    check("m1_done_count", done, 1);
    check("m1_err_count", err, 0);
    check("m1_master_clr", master_frame_o, 0);

    // Simultaneous requests: slave wins, master launched after the gap
    s_req_i = 1; m_req_i = 1; s_len_i = 7'd4; m_len_i = 7'd9;
    step();
    check("arb_s_ack", s_ack_o, 1);
    check("arb_m_ack", m_ack_o, 0);
    check("arb_slave", slave_frame_o, 1);
    check("arb_master", master_frame_o, 0);
    check("arb_len", data_length_o, 4);
    s_req_i = 0;
    wait_strobe_end(n);
    check("arb_strobe_len", n, 16);
    repeat (5) step();
    frame_over_i = 1;
    step();
    check("arb_done", tx_done_o, 1);
    frame_over_i = 0;
    wait_idle(n, sf, err, done, ack);
    check("arb_gap", n, 48);
    check("arb_gap_acks", ack, 0);
    step();
    check("arb_m_launch", m_ack_o, 1);
    check("arb_m_master", master_frame_o, 1);
    check("arb_m_len", data_length_o, 9);
    m_req_i = 0;
    // frame_over already high entering WAIT_DONE is not an edge
    frame_over_i = 1;
    wait_strobe_end(n);
    done = 0;
    repeat (10) begin
      done += int'(tx_done_o);
      step();
    end
    check("stale_fo_no_done", done, 0);
    frame_over_i = 0;
    step();
    frame_over_i = 1;
    step();
    check("fresh_fo_done", tx_done_o, 1);
    frame_over_i = 0;
    wait_idle(n, sf, err, done, ack);
    check("arb_m_gap", n, 48);

    // Bad lengths 0 and 65
    m_req_i = 1; m_len_i = 7'd0;
    step();
    check("len0_ack", m_ack_o, 1);
    check("len0_err", tx_error_o, 1);
    m_req_i = 0;
    wait_idle(n, sf, err, done, ack);
    check("len0_gap", n, 48);
    check("len0_no_send", sf, 0);
    check("len0_err_count", err, 1);
    m_req_i = 1; m_len_i = 7'd65;
    step();
    check("len65_ack", m_ack_o, 1);
    check("len65_err", tx_error_o, 1);
    m_req_i = 0;
    wait_idle(n, sf, err, done, ack);
    check("len65_gap", n, 48);
    check("len65_no_send", sf, 0);

    // Timeout with frame_over never asserted; 64 is a legal length
    m_req_i = 1; m_len_i = 7'd64;
    step();
    check("to_send", send_frame_o, 1);
    check("to_no_err", tx_error_o, 0);
    m_req_i = 0;
    wait_strobe_end(n);
    n = 0;
    while (!tx_error_o && n < 40000) begin
      step();
      n++;
    end
    check("to_cycles", n, 32767);
    check("to_no_done", tx_done_o, 0);
    wait_idle(n, sf, err, done, ack);
    check("to_gap", n, 48);
    check("to_done_count", done, 0);

    // decode_over gates launch; ignored once running
    decode_over_i = 1; m_req_i = 1; m_len_i = 7'd5;
    step();
    step();
    check("dec_no_launch", {tx_busy_o, m_ack_o}, 0);
    decode_over_i = 0;
    step();
    check("dec_launch", m_ack_o, 1);
    check("dec_send", send_frame_o, 1);
    m_req_i = 0;
    decode_over_i = 1;
    wait_strobe_end(n);
    check("dec_strobe_len", n, 16);
    repeat (3) step();
    frame_over_i = 1;
    step();
    check("dec_done", tx_done_o, 1);
    frame_over_i = 0;
    decode_over_i = 0;
    wait_idle(n, sf, err, done, ack);
    check("dec_gap", n, 48);

    // Reset in cycle 5 of STROBE
    m_req_i = 1; m_len_i = 7'd3;
    step();
    m_req_i = 0;
    repeat (4) step();
    check("rst_mid_send", send_frame_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    check("rst_mid_send_drop", send_frame_o, 0);
    check("rst_mid_busy", tx_busy_o, 0);
    check("rst_mid_len", data_length_o, 0);
    @(negedge clk_i) rst_ni = 1'b1;
    step();
    n = 0;
    repeat (60) begin
      n += int'(tx_busy_o | send_frame_o | m_ack_o | s_ack_o | tx_done_o | tx_error_o);
      step();
    end
    check("rst_mid_quiet", n, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
